// File: rtl/axi4_wr_rr_arbiter_if.sv
// rtl/axi4_wr_rr_arbiter_if.sv - AXI4 write-side (AW/W/B) interface with master_wr and slaver_wr modports
interface axi_inf #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ID_W-1:0]     axi_awid;
    logic [ADDR_W-1:0]   axi_awaddr;
    logic [7:0]          axi_awlen;
    logic [2:0]          axi_awsize;
    logic [1:0]          axi_awburst;
    logic                axi_awvalid;
    logic                axi_awready;
    logic [DATA_W-1:0]   axi_wdata;
    logic [DATA_W/8-1:0] axi_wstrb;
    logic                axi_wlast;
    logic                axi_wvalid;
    logic                axi_wready;
    logic [ID_W-1:0]     axi_bid;
    logic [1:0]          axi_bresp;
    logic                axi_bvalid;
    logic                axi_bready;

    // Side that issues write transactions
    modport master_wr (
        output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_bvalid,
        output axi_bready
    );

    // Side that accepts write transactions
    modport slaver_wr (
        input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bid, axi_bresp, axi_bvalid,
        input  axi_bready
    );
endinterface

// File: rtl/axi4_wr_rr_arbiter.sv
// rtl/axi4_wr_rr_arbiter.sv - round-robin arbiter sharing one AXI4 write port among NUM requesters
module axi4_wr_rr_arbiter #(
    parameter int NUM    = 4,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int IDX_W = $clog2(NUM)
) (
    input  logic             clock,
    input  logic             rst,
    axi_inf.slaver_wr        s_inf [NUM-1:0],
    axi_inf.master_wr        m_inf,
    output logic             grant_vld,
    output logic [IDX_W-1:0] grant_idx
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AW   = 2'd1;
    localparam logic [1:0] S_W    = 2'd2;
    localparam logic [1:0] S_B    = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] rr_ptr;

    logic [NUM-1:0]      aw_valid;
    logic [NUM-1:0]      w_valid;
    logic [NUM-1:0]      w_last;
    logic [NUM-1:0]      b_ready;
    logic [ID_W-1:0]     aw_id    [NUM];
    logic [ADDR_W-1:0]   aw_addr  [NUM];
    logic [7:0]          aw_len   [NUM];
    logic [2:0]          aw_size  [NUM];
    logic [1:0]          aw_burst [NUM];
    logic [DATA_W-1:0]   w_data   [NUM];
    logic [DATA_W/8-1:0] w_strb   [NUM];

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;

    logic aw_hs;
    logic w_last_hs;
    logic b_hs;

    // Interface arrays only accept constant indices, so flatten each port into
    // plain arrays here and gate its ready/bvalid by ownership and phase.
    for (genvar g = 0; g < NUM; g++) begin : g_port
        logic owner;
        assign owner       = (grant == IDX_W'(g));
        assign aw_valid[g] = s_inf[g].axi_awvalid;
        assign w_valid[g]  = s_inf[g].axi_wvalid;
        assign w_last[g]   = s_inf[g].axi_wlast;
        assign b_ready[g]  = s_inf[g].axi_bready;
        assign aw_id[g]    = s_inf[g].axi_awid;
        assign aw_addr[g]  = s_inf[g].axi_awaddr;
        assign aw_len[g]   = s_inf[g].axi_awlen;
        assign aw_size[g]  = s_inf[g].axi_awsize;
        assign aw_burst[g] = s_inf[g].axi_awburst;
        assign w_data[g]   = s_inf[g].axi_wdata;
        assign w_strb[g]   = s_inf[g].axi_wstrb;

        assign s_inf[g].axi_awready = owner && (state == S_AW) && m_inf.axi_awready;
        assign s_inf[g].axi_wready  = owner && (state == S_W)  && m_inf.axi_wready;
        assign s_inf[g].axi_bvalid  = owner && (state == S_B)  && m_inf.axi_bvalid;
        assign s_inf[g].axi_bid     = m_inf.axi_bid;
        assign s_inf[g].axi_bresp   = m_inf.axi_bresp;
    end

    // Payload always follows the owner; only the valids are phase-gated.
    assign m_inf.axi_awid    = aw_id[grant];
    assign m_inf.axi_awaddr  = aw_addr[grant];
    assign m_inf.axi_awlen   = aw_len[grant];
    assign m_inf.axi_awsize  = aw_size[grant];
    assign m_inf.axi_awburst = aw_burst[grant];
    assign m_inf.axi_wdata   = w_data[grant];
    assign m_inf.axi_wstrb   = w_strb[grant];
    assign m_inf.axi_wlast   = w_last[grant];
    assign m_inf.axi_awvalid = (state == S_AW) && aw_valid[grant];
    assign m_inf.axi_wvalid  = (state == S_W)  && w_valid[grant];
    assign m_inf.axi_bready  = (state == S_B)  && b_ready[grant];

    assign aw_hs     = m_inf.axi_awvalid && m_inf.axi_awready;
    assign w_last_hs = m_inf.axi_wvalid && m_inf.axi_wready && m_inf.axi_wlast;
    assign b_hs      = m_inf.axi_bvalid && m_inf.axi_bready;

    assign grant_vld = (state != S_IDLE);
    assign grant_idx = grant;

    // Round-robin pick: scan downward so the first requester at or after rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NUM - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM);
            if (aw_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Transaction FSM: grant is held from AW through the B handshake.
    always_ff @(posedge clock) begin
        if (rst) begin
            state  <= S_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                S_IDLE: if (pick_vld) begin
                    grant <= pick_idx;
                    state <= S_AW;
                end
                S_AW: if (aw_hs) state <= S_W;
                S_W:  if (w_last_hs) state <= S_B;
                S_B: if (b_hs) begin
                    rr_ptr <= (grant == IDX_W'(NUM - 1)) ? '0 : grant + 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_wr_rr_arbiter.sv
// tb/tb_axi4_wr_rr_arbiter.sv - self-checking bench for axi4_wr_rr_arbiter
module tb_axi4_wr_rr_arbiter;
    localparam int NUM    = 4;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clock = 1'b0;
    logic rst;
    always #5 clock = ~clock;

    axi_inf #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_inf [NUM-1:0] ();
    axi_inf #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_inf ();

    logic       grant_vld;
    logic [1:0] grant_idx;

    axi4_wr_rr_arbiter #(.NUM(NUM), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock     (clock),
        .rst       (rst),
        .s_inf     (s_inf),
        .m_inf     (m_inf),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    logic [NUM-1:0]    s_awvalid, s_wvalid, s_wlast, s_bready;
    logic [NUM-1:0]    s_awready, s_wready, s_bvalid;
    logic [ADDR_W-1:0] s_awaddr [NUM];
    logic [7:0]        s_awlen  [NUM];
    logic [DATA_W-1:0] s_wdata  [NUM];
    logic [1:0]        s_bresp  [NUM];
    logic [ID_W-1:0]   s_bid    [NUM];
    logic              m_awready, m_wready, m_bvalid;
    logic [1:0]        m_bresp;
    logic [ID_W-1:0]   m_bid;

    for (genvar g = 0; g < NUM; g++) begin : g_drv
        assign s_inf[g].axi_awid    = ID_W'(g);
        assign s_inf[g].axi_awaddr  = s_awaddr[g];
        assign s_inf[g].axi_awlen   = s_awlen[g];
        assign s_inf[g].axi_awsize  = 3'd2;
        assign s_inf[g].axi_awburst = 2'd1;
        assign s_inf[g].axi_awvalid = s_awvalid[g];
        assign s_inf[g].axi_wdata   = s_wdata[g];
        assign s_inf[g].axi_wstrb   = '1;
        assign s_inf[g].axi_wlast   = s_wlast[g];
        assign s_inf[g].axi_wvalid  = s_wvalid[g];
        assign s_inf[g].axi_bready  = s_bready[g];
        assign s_awready[g] = s_inf[g].axi_awready;
        assign s_wready[g]  = s_inf[g].axi_wready;
        assign s_bvalid[g]  = s_inf[g].axi_bvalid;
        assign s_bresp[g]   = s_inf[g].axi_bresp;
        assign s_bid[g]     = s_inf[g].axi_bid;
    end

    assign m_inf.axi_awready = m_awready;
    assign m_inf.axi_wready  = m_wready;
    assign m_inf.axi_bvalid  = m_bvalid;
    assign m_inf.axi_bresp   = m_bresp;
    assign m_inf.axi_bid     = m_bid;

    typedef struct {
        logic [3:0]  awv;
        logic [3:0]  wv;
        logic [3:0]  wl;
        logic [3:0]  br;
        logic        mar;
        logic        mwr;
        logic        mbv;
        logic [17:0] exp; // {gvld, gidx[1:0], m_awvalid, m_wvalid, m_bready, awready[3:0], wready[3:0], bvalid[3:0]}
    } vec_t;

    vec_t vt [12];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
        m_bresp = 2'b00; m_bid = 4'd2;
        for (int i = 0; i < NUM; i++) begin
            s_awaddr[i] = 32'h1000 * i;
            s_awlen[i]  = 8'd3;
            s_wdata[i]  = 32'hA000 + i;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    function automatic logic [17:0] obs();
        return {grant_vld, grant_idx, m_inf.axi_awvalid, m_inf.axi_wvalid, m_inf.axi_bready,
                s_awready, s_wready, s_bvalid};
    endfunction

    int  wbeat, nrec, nb;
    int  aw_seen, beat_in, beats_out, b_wait;
    logic aw_done, w_done, b_done, done;

    initial begin
        // Single write from port 2 (awlen=3, early W, delayed B), then a wrap pick to port 3.
        vt[0]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, {1'b0, 2'd0, 3'b000, 4'b0000, 4'b0000, 4'b0000}};
        vt[1]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, {1'b0, 2'd0, 3'b000, 4'b0000, 4'b0000, 4'b0000}};
        vt[2]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, {1'b1, 2'd2, 3'b100, 4'b0100, 4'b0000, 4'b0000}};
        vt[3]  = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, {1'b1, 2'd2, 3'b010, 4'b0000, 4'b0100, 4'b0000}};
        vt[4]  = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, {1'b1, 2'd2, 3'b010, 4'b0000, 4'b0100, 4'b0000}};
        vt[5]  = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, {1'b1, 2'd2, 3'b010, 4'b0000, 4'b0100, 4'b0000}};
        vt[6]  = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, {1'b1, 2'd2, 3'b010, 4'b0000, 4'b0100, 4'b0000}};
        vt[7]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0, {1'b1, 2'd2, 3'b001, 4'b0000, 4'b0000, 4'b0000}};
        vt[8]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b1, 1'b1, {1'b1, 2'd2, 3'b001, 4'b0000, 4'b0000, 4'b0100}};
        vt[9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, {1'b0, 2'd2, 3'b000, 4'b0000, 4'b0000, 4'b0000}};
        vt[10] = '{4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, {1'b0, 2'd2, 3'b000, 4'b0000, 4'b0000, 4'b0000}};
        vt[11] = '{4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, {1'b1, 2'd3, 3'b100, 4'b0000, 4'b0000, 4'b0000}};

        // Reset then idle, with downstream and W lines busy but no awvalid anywhere.
        do_reset();
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; s_wvalid = '1; s_bready = '1;
        for (int c = 0; c < 20; c++) begin
            #1;
            check("idle_quiet", 64'(obs()), 64'd0);
            cycle();
        end

        // Table-driven single write and wrap pick.
        do_reset();
        wbeat = 0;
        for (int i = 0; i < 12; i++) begin
            s_awvalid = vt[i].awv; s_wvalid = vt[i].wv; s_wlast = vt[i].wl; s_bready = vt[i].br;
            m_awready = vt[i].mar; m_wready = vt[i].mwr; m_bvalid = vt[i].mbv;
            s_wdata[2] = 32'h2000_0000 + wbeat;
            #1;
            check($sformatf("vec%0d", i), 64'(obs()), 64'(vt[i].exp));
            if (i == 2) begin
                check("aw_addr", 64'(m_inf.axi_awaddr), 64'(32'h2000));
                check("aw_len", 64'(m_inf.axi_awlen), 64'd3);
            end
            if (m_inf.axi_wvalid && m_inf.axi_wready) begin
                check("beat_data", 64'(m_inf.axi_wdata), 64'(32'h2000_0000 + wbeat));
                check("beat_last", 64'(m_inf.axi_wlast), 64'(wbeat == 3));
                wbeat++;
            end
            if (s_bvalid[2]) begin
                check("bresp_okay", 64'(s_bresp[2]), 64'd0);
                check("bid", 64'(s_bid[2]), 64'd2);
            end
            cycle();
        end
        check("beat_count", 64'(wbeat), 64'd4);

        // Fairness: all ports request continuously with single-beat writes.
        do_reset();
        s_awvalid = '1; s_wvalid = '1; s_wlast = '1; s_bready = '1;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
        nrec = 0;
        for (int c = 0; c < 60 && nrec < 6; c++) begin
            #1;
            if (m_inf.axi_awvalid && m_inf.axi_awready) begin
                check("fair_grant", 64'(grant_idx), 64'(nrec % 4));
                check("fair_addr", 64'(m_inf.axi_awaddr), 64'(32'h1000 * (nrec % 4)));
                nrec++;
            end
            cycle();
        end
        check("fair_count", 64'(nrec), 64'd6);

        // Backpressure: awready low 5 cycles, wready toggling, bvalid 7 cycles late.
        do_reset();
        s_awvalid = 4'b1010; s_bready = 4'b1010; s_wvalid[0] = 1'b1;
        aw_seen = 0; beat_in = 0; beats_out = 0; b_wait = 0;
        aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0;
        for (int c = 0; c < 80 && !b_done; c++) begin
            s_awvalid[1] = !aw_done;
            s_wvalid[1]  = (beat_in < 4);
            s_wlast[1]   = (beat_in == 3);
            s_wdata[1]   = 32'hB000 + beat_in;
            m_awready    = (aw_seen >= 5);
            m_wready     = c[0];
            m_bvalid     = w_done && (b_wait >= 7);
            #1;
            if (!aw_done) check("early_w_held", 64'({m_inf.axi_wvalid, s_wready}), 64'd0);
            check("bvalid_mirror", 64'(s_bvalid), 64'({2'b00, m_bvalid, 1'b0}));
            check("other_wready", 64'(s_wready & 4'b1101), 64'd0);
            if (w_done) b_wait++;
            if (m_inf.axi_awvalid) aw_seen++;
            if (m_inf.axi_awvalid && m_inf.axi_awready) aw_done = 1'b1;
            if (s_wvalid[1] && s_wready[1]) beat_in++;
            if (m_inf.axi_wvalid && m_inf.axi_wready) begin
                check("bp_wdata", 64'(m_inf.axi_wdata), 64'(32'hB000 + beats_out));
                check("bp_wlast", 64'(m_inf.axi_wlast), 64'(beats_out == 3));
                if (m_inf.axi_wlast) w_done = 1'b1;
                beats_out++;
            end
            if (m_inf.axi_bvalid && m_inf.axi_bready) b_done = 1'b1;
            cycle();
        end
        check("bp_b_done", 64'(b_done), 64'd1);
        check("bp_beats", 64'(beats_out), 64'd4);
        check("bp_aw_stall", 64'(aw_seen), 64'd6);
        check("bp_turn_idle", 64'({grant_vld, m_inf.axi_awvalid}), 64'd0);
        cycle();
        check("bp_next_grant", 64'({grant_vld, grant_idx, m_inf.axi_awvalid}), 64'({1'b1, 2'd3, 1'b1}));

        // Reset mid-burst, after a full transaction moved rr_ptr away from 0.
        do_reset();
        s_awvalid = 4'b0100; s_wvalid = 4'b0100; s_wlast = 4'b0100; s_bready = 4'b0100;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (m_inf.axi_bvalid && m_inf.axi_bready) done = 1'b1;
            cycle();
        end
        check("rm_first_txn", 64'(done), 64'd1);
        s_wlast = '0; m_bvalid = 1'b0;
        nb = 0;
        for (int c = 0; c < 20 && nb < 2; c++) begin
            #1;
            if (m_inf.axi_wvalid && m_inf.axi_wready) nb++;
            cycle();
        end
        check("rm_two_beats", 64'(nb), 64'd2);
        check("rm_mid_burst", 64'({grant_vld, grant_idx, m_inf.axi_wvalid}), 64'({1'b1, 2'd2, 1'b1}));
        rst = 1'b1;
        s_awvalid = 4'b1010;
        cycle();
        check("rm_after_rst", 64'({grant_vld, m_inf.axi_awvalid, m_inf.axi_wvalid, m_inf.axi_bready, s_wready}), 64'd0);
        rst = 1'b0;
        cycle();
        check("rm_regrant", 64'({grant_vld, grant_idx, m_inf.axi_awvalid}), 64'({1'b1, 2'd1, 1'b1}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
